// File: rtl/sc_stream_gen.sv
// Stochastic-computing stream generator: WIDTH-bit magnitude -> LEN-bit unipolar stream
// from a Gray-code Sobol sequence. Optional ones counter: define SC_STREAM_ONES_CNT_EN.
module sc_stream_gen #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LEN   = 32
`ifdef SC_STREAM_ONES_CNT_EN
  ,
  localparam int unsigned CW   = $clog2(LEN + 1)
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         num,
  input  logic [WIDTH*WIDTH-1:0]   m,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LEN-1:0]           seq
`ifdef SC_STREAM_ONES_CNT_EN
  ,
  output logic [CW-1:0]            ones_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  localparam logic [WIDTH-1:0] KLast = WIDTH'(LEN - 1);

  state_e                   r_state;
  logic [WIDTH-1:0]         r_num;
  logic [WIDTH*WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]         r_k;
  logic [WIDTH-1:0]         r_x;
  logic [LEN-1:0]           r_seq;
  logic                     r_out_valid;
`ifdef SC_STREAM_ONES_CNT_EN
  logic [CW-1:0]            r_ones;
`endif

  logic [WIDTH-1:0]         w_v;
  logic                     w_found;
  logic                     w_bit;
  logic [LEN-1:0]           w_seq_nxt;

  // Direction number indexed by the count of trailing ones of k (first zero bit).
  always_comb begin
    w_v     = '0;
    w_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!w_found && !r_k[i]) begin
        w_v     = r_m[i*WIDTH +: WIDTH];
        w_found = 1'b1;
      end
    end
  end

  assign w_bit     = (r_num > r_x);
  assign w_seq_nxt = r_seq | (LEN'(w_bit) << r_k);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_num       <= '0;
      r_m         <= '0;
      r_k         <= '0;
      r_x         <= '0;
      r_seq       <= '0;
      r_out_valid <= 1'b0;
`ifdef SC_STREAM_ONES_CNT_EN
      r_ones      <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_state <= StRun;
            r_num   <= num;
            r_m     <= m;
            r_k     <= '0;
            r_x     <= '0;
            r_seq   <= '0;
`ifdef SC_STREAM_ONES_CNT_EN
            r_ones  <= '0;
`endif
          end
        end
        StRun: begin
          if (abort) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end else begin
            r_seq <= w_seq_nxt;
            r_x   <= r_x ^ w_v;
`ifdef SC_STREAM_ONES_CNT_EN
            r_ones <= r_ones + CW'(w_bit);
`endif
            if (r_k == KLast) begin
              r_k         <= '0;
              r_state     <= StHold;
              r_out_valid <= 1'b1;
            end else begin
              r_k <= r_k + WIDTH'(1);
            end
          end
        end
        StHold: begin
          if (abort || out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign seq       = r_seq;
`ifdef SC_STREAM_ONES_CNT_EN
  assign ones_cnt  = r_ones;
`endif

endmodule

// File: tb/tb_sc_stream_gen.sv
// Directed, table-driven bench for sc_stream_gen (WIDTH=6, LEN=32, v_j = 1<<(5-j)).
module tb_sc_stream_gen;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned LEN   = 32;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       num;
  logic [WIDTH*WIDTH-1:0] m;
  logic                   abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [LEN-1:0]         seq;
`ifdef SC_STREAM_ONES_CNT_EN
  logic [5:0]             ones_cnt;
`endif

  sc_stream_gen #(.WIDTH(WIDTH), .LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .m         (m),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .seq       (seq)
`ifdef SC_STREAM_ONES_CNT_EN
    ,
    .ones_cnt  (ones_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0]  num;
    logic [31:0] seq;
    int          ones;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ones(input string name, input int exp);
`ifdef SC_STREAM_ONES_CNT_EN
    check(name, 64'(ones_cnt), 64'(exp));
`else
    if (exp < 0) $display("unexpected ones value %0d for %s", exp, name);
`endif
  endtask

  // Present a request at a negedge; returns at the negedge right after acceptance edge E0.
  task automatic send(input logic [5:0] n);
    @(negedge clk);
    in_valid = 1'b1;
    num      = n;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Negedges elapsed until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // x<16 only where gray(k) has bits 1:0 clear, i.e. k mod 8 in {0,7}.
    vecs[0] = '{num: 6'd32, seq: 32'h99999999, ones: 16};
    vecs[1] = '{num: 6'd0,  seq: 32'h00000000, ones: 0};
    vecs[2] = '{num: 6'd63, seq: 32'hFFFFFFFF, ones: 32};
    vecs[3] = '{num: 6'd16, seq: 32'h81818181, ones: 8};
    vecs[4] = '{num: 6'd8,  seq: 32'h80018001, ones: 4};
    vecs[5] = '{num: 6'd1,  seq: 32'h00000001, ones: 1};
    vecs[6] = '{num: 6'd62, seq: 32'hFFDFFFFF, ones: 31};

    m         = {6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    in_valid  = 1'b0;
    num       = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset seq", 64'(seq), 64'd0);
    check_ones("reset ones_cnt", 0);
    rst = 1'b1;

    // Table-driven streams with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].num);
      wait_valid(lat);
      check($sformatf("latency num=%0d", vecs[i].num), 64'(lat), 64'd32);
      check($sformatf("seq num=%0d", vecs[i].num), 64'(seq), 64'(vecs[i].seq));
      check_ones($sformatf("ones num=%0d", vecs[i].num), vecs[i].ones);
    end
    @(negedge clk);
    check("idle after handshake", 64'(in_ready), 64'd1);

    // Backpressure with an ignored request in HOLD.
    out_ready = 1'b0;
    send(6'd32);
    wait_valid(lat);
    check("bp latency", 64'(lat), 64'd32);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp hold %0d", c), {seq, 29'd0, in_ready, out_valid, 1'b0},
            {32'h99999999, 29'd0, 1'b0, 1'b1, 1'b0});
      if (c == 3) begin
        in_valid = 1'b1;
        num      = 6'd5;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp release out_valid", 64'(out_valid), 64'd0);
    send(6'd63);
    wait_valid(lat);
    check("after bp seq", 64'(seq), 64'hFFFFFFFF);

    // Abort at step k=10: partial seq keeps bits 0..9 of 0x99999999.
    send(6'd32);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort partial seq", 64'(seq), 64'h199);
    check_ones("abort partial ones", 5);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) lat++;
      @(negedge clk);
    end
    check("abort no out_valid", 64'(lat), 64'd0);
    send(6'd16);
    wait_valid(lat);
    check("post-abort seq", 64'(seq), 64'h81818181);
    check_ones("post-abort ones", 8);

    // Abort while idle does not block acceptance.
    @(negedge clk);
    abort = 1'b1;
    send(6'd1);
    abort = 1'b0;
    check("idle abort accepted", 64'(in_ready), 64'd0);
    wait_valid(lat);
    check("idle abort seq", 64'(seq), 64'h1);

    // Asynchronous reset mid-RUN.
    send(6'd32);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst seq", 64'(seq), 64'd0);
    check("async rst flags", {62'd0, in_ready, out_valid}, 64'd2);
    check_ones("async rst ones", 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(6'd32);
    wait_valid(lat);
    check("post-rst latency", 64'(lat), 64'd32);
    check("post-rst seq", 64'(seq), 64'h99999999);

    // Back-to-back, alternating 32/0, one stream every 34 cycles.
    @(negedge clk);
    @(negedge clk);
    begin
      int found = 0;
      int last  = 0;
      in_valid = 1'b1;
      num      = 6'd32;
      for (int c = 0; c < 200 && found < 4; c++) begin
        @(negedge clk);
        if (out_valid) begin
          check($sformatf("b2b seq %0d", found), 64'(seq),
                (found % 2 == 0) ? 64'h99999999 : 64'h0);
          if (found > 0) check($sformatf("b2b period %0d", found), 64'(c - last), 64'd34);
          last = c;
          found++;
          num = (found % 2 == 0) ? 6'd32 : 6'd0;
        end
      end
      in_valid = 1'b0;
      check("b2b stream count", 64'(found), 64'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
